fp_from_int_pipe: RTL and testbench

Pipelined, synthesisable integer-to-IEEE-754 single-precision converter with parametrised input width and latency, plus a per-operation signed/unsigned select. It replaces the fixed-width, signed-only, simulation-only converters in the floating-point unit. It accepts one operand per enabled cycle and carries a valid bit, a stall enable and an inexact flag alongside the result.

---
 rtl/fp_from_int_pipe_pkg.sv | 21 ++
 rtl/fp_from_int_pipe_lzc.sv | 23 ++
 rtl/fp_from_int_pipe.sv | 107 ++++++++++
 tb/tb_fp_from_int_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_from_int_pipe_pkg.sv
// Shared FP32 field constants and types for the integer-to-float converter.
package fp_from_int_pipe_pkg;

   localparam int BIAS   = 127;
   localparam int FRAC_W = 23;
   localparam int EXP_W  = 8;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   // Payload carried by stage 3 and every delay stage behind it.
   typedef struct packed {
      logic  valid;
      fp32_t q;
      logic  inexact;
   } conv_stage_t;

endpackage

// File: rtl/fp_from_int_pipe_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module lzc #(
   parameter int W  = 33,
   parameter int OW = $clog2(W + 1)
) (
   input  logic [W-1:0]  in,
   output logic [OW-1:0] count
);

   logic found;

   always_comb begin
      count = OW'(W);
      found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!found && in[i]) begin
            count = OW'(W - 1 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_from_int_pipe.sv
// Pipelined signed/unsigned integer to FP32 converter, round to nearest even.
// Stages: magnitude, leading-zero count, normalise+round, then a plain delay tail.
module fp_from_int_pipe
   import fp_from_int_pipe_pkg::*;
#(
   parameter int IN_WIDTH = 33,
   parameter int LATENCY  = 7
) (
   input  logic                clk,
   input  logic                areset,
   input  logic                en,
   input  logic                in_valid,
   input  logic [IN_WIDTH-1:0] a,
   input  logic                is_signed,
   output logic                out_valid,
   output logic [31:0]         q,
   output logic                inexact
);

   localparam int LZW = $clog2(IN_WIDTH + 1);
   // Working width is at least 26 so fraction, guard and sticky always exist.
   localparam int NW  = (IN_WIDTH > 26) ? IN_WIDTH : 26;
   localparam int PAD = NW - IN_WIDTH;

   logic                v1, sign1;
   logic [IN_WIDTH-1:0] mag1;
   logic                v2, sign2, zero2;
   logic [IN_WIDTH-1:0] mag2;
   logic [LZW-1:0]      lz1, lz2;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         v1    <= 1'b0;
         sign1 <= 1'b0;
         mag1  <= '0;
      end else if (en) begin
         v1    <= in_valid;
         sign1 <= is_signed & a[IN_WIDTH-1];
         mag1  <= (is_signed & a[IN_WIDTH-1]) ? -a : a;
      end
   end

   lzc #(.W(IN_WIDTH), .OW(LZW)) u_lzc (
      .in    (mag1),
      .count (lz1)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         v2    <= 1'b0;
         sign2 <= 1'b0;
         zero2 <= 1'b0;
         mag2  <= '0;
         lz2   <= '0;
      end else if (en) begin
         v2    <= v1;
         sign2 <= sign1;
         zero2 <= (mag1 == '0);
         mag2  <= mag1;
         lz2   <= lz1;
      end
   end

   logic [IN_WIDTH-1:0] norm;
   logic [NW-1:0]       ext;
   logic [FRAC_W-1:0]   frac, frac_r;
   logic                guard, sticky, rnd, carry;
   conv_stage_t         res;

   always_comb begin
      norm   = mag2 << lz2;
      ext    = NW'(norm) << PAD;
      frac   = ext[NW-2 -: FRAC_W];
      guard  = ext[NW-FRAC_W-2];
      sticky = |ext[NW-FRAC_W-3:0];
      rnd    = guard & (sticky | frac[0]);
      {carry, frac_r} = {1'b0, frac} + {{FRAC_W{1'b0}}, rnd};
      res       = '0;
      res.valid = v2;
      if (!zero2) begin
         res.q.sign  = sign2;
         res.q.exp   = EXP_W'(BIAS + IN_WIDTH - 1) - EXP_W'(lz2) + EXP_W'(carry);
         res.q.frac  = frac_r;
         res.inexact = guard | sticky;
      end
   end

   // tail[0] is the stage-3 register; tail[k] are the pure delay stages.
   conv_stage_t tail [LATENCY-2];

   always_ff @(posedge clk or posedge areset) begin
      if (areset)  tail[0] <= '0;
      else if (en) tail[0] <= res;
   end

   for (genvar k = 1; k <= LATENCY - 3; k++) begin : g_tail
      always_ff @(posedge clk or posedge areset) begin
         if (areset)  tail[k] <= '0;
         else if (en) tail[k] <= tail[k-1];
      end
   end

   assign out_valid = tail[LATENCY-3].valid;
   assign q         = tail[LATENCY-3].q;
   assign inexact   = tail[LATENCY-3].inexact;

endmodule

// File: tb/tb_fp_from_int_pipe.sv
// Bench for fp_from_int_pipe: five parameter sets share clk/en/reset/valid,
// each checked against an arithmetic FP32 conversion model via delay queues.
module tb_fp_from_int_pipe;

   localparam int NI = 5;

   function automatic int cfg_w(input int g);
      case (g)
         0: return 33;
         1: return 2;
         2: return 24;
         3: return 25;
         default: return 64;
      endcase
   endfunction

   function automatic int cfg_l(input int g);
      return (g == 1 || g == 3) ? 3 : 7;
   endfunction

   logic        clk = 1'b0;
   logic        areset, en, in_valid;
   logic [63:0] sw_a [NI];
   logic        sw_s [NI];
   logic        sw_v [NI];
   logic [31:0] sw_q [NI];
   logic        sw_x [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = cfg_w(g);
      localparam int L = cfg_l(g);
      fp_from_int_pipe #(.IN_WIDTH(W), .LATENCY(L)) dut (
         .clk       (clk),
         .areset    (areset),
         .en        (en),
         .in_valid  (in_valid),
         .a         (sw_a[g][W-1:0]),
         .is_signed (sw_s[g]),
         .out_valid (sw_v[g]),
         .q         (sw_q[g]),
         .inexact   (sw_x[g])
      );
   end

   int n_vec = 0;
   int n_err = 0;
   logic [33:0] hist [NI][$];
   logic [33:0] last [NI];

   // Returns {inexact, q}: magnitude, floor(log2), then round-half-even on the remainder.
   function automatic logic [32:0] ref_conv(input logic [63:0] av, input int w, input bit sgn);
      logic [63:0] mask, val, mag, mant, rem, half;
      bit neg, inx;
      int p, sh;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      val  = av & mask;
      neg  = sgn && val[w-1];
      mag  = neg ? ((~val + 64'd1) & mask) : val;
      if (mag == 64'd0) return 33'd0;
      p = 63;
      while (!mag[p]) p--;
      inx = 1'b0;
      if (p <= 23) begin
         mant = mag << (23 - p);
      end else begin
         sh   = p - 23;
         mant = mag >> sh;
         rem  = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         inx  = (rem != 64'd0);
         if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
         if (mant[24]) begin
            mant = mant >> 1;
            p++;
         end
      end
      return {inx, neg, 8'(p + 127), mant[22:0]};
   endfunction

   function automatic logic [63:0] rand_operand();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'd1 << $urandom_range(0, 63);
         3: return r >> $urandom_range(30, 63);
         4: return r >> $urandom_range(0, 40);
         default: return r;
      endcase
   endfunction

   task automatic clear_model();
      for (int g = 0; g < NI; g++) begin
         hist[g].delete();
         last[g] = '0;
      end
   endtask

   task automatic check_zero(input string tag);
      for (int g = 0; g < NI; g++) begin
         n_vec++;
         assert ({sw_v[g], sw_x[g], sw_q[g]} === 34'd0) else begin
            n_err++;
            $error("FAIL %s inst%0d got v=%b x=%b q=%h want all zero", tag, g, sw_v[g], sw_x[g], sw_q[g]);
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int g = 0; g < NI; g++) begin
         n_vec++;
         assert (sw_v[g] === last[g][33]) else begin
            n_err++;
            $error("FAIL %s valid inst%0d got %b want %b", tag, g, sw_v[g], last[g][33]);
         end
         if (last[g][33]) begin
            n_vec++;
            assert ({sw_x[g], sw_q[g]} === last[g][32:0]) else begin
               n_err++;
               $error("FAIL %s result inst%0d got x=%b q=%h want x=%b q=%h",
                      tag, g, sw_x[g], sw_q[g], last[g][32], last[g][31:0]);
            end
         end
      end
   endtask

   // One clock: drive inputs, advance the model on enabled edges, check after the edge.
   // exp_idx selects an instance whose expectation is a fixed constant instead of the model.
   task automatic step(input bit e, input bit v, input logic [63:0] av, input bit sv,
                       input bit all_same, input int exp_idx, input logic [32:0] exp_val,
                       input string tag);
      logic [33:0] ent [NI];
      en       = e;
      in_valid = v;
      for (int g = 0; g < NI; g++) begin
         if (g == 0 || all_same) begin
            sw_a[g] = av;
            sw_s[g] = sv;
         end else begin
            sw_a[g] = rand_operand();
            sw_s[g] = 1'($urandom_range(0, 1));
         end
         ent[g] = {v, (g == exp_idx) ? exp_val : ref_conv(sw_a[g], cfg_w(g), sw_s[g])};
      end
      @(posedge clk);
      if (e) begin
         for (int g = 0; g < NI; g++) begin
            hist[g].push_back(ent[g]);
            if (hist[g].size() == cfg_l(g)) last[g] = hist[g].pop_front();
            else last[g] = '0;
         end
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic rand_step(input bit e, input bit v, input string tag);
      step(e, v, rand_operand(), 1'($urandom_range(0, 1)), 1'b0, -1, 33'd0, tag);
   endtask

   initial begin
      areset   = 1'b0;
      en       = 1'b0;
      in_valid = 1'b0;
      for (int g = 0; g < NI; g++) begin
         sw_a[g] = '0;
         sw_s[g] = 1'b0;
      end
      clear_model();
      #2 areset = 1'b1;
      #1 check_zero("reset_async");
      @(posedge clk);
      #1 check_zero("reset_hold");
      areset = 1'b0;

      // Directed values on the 33-bit / latency-7 instance.
      step(1, 1, 64'h1_FFFF_FFFF, 1, 0, 0, {1'b0, 32'hBF80_0000}, "signed_minus1");
      step(1, 1, 64'h1_0000_0000, 1, 0, 0, {1'b0, 32'hCF80_0000}, "signed_min");
      step(1, 1, 64'h1_FFFF_FFFF, 0, 0, 0, {1'b1, 32'h5000_0000}, "unsigned_max");
      step(1, 1, 64'd0,           0, 0, 0, {1'b0, 32'h0000_0000}, "zero");
      step(1, 1, 64'd16777217,    0, 0, 0, {1'b1, 32'h4B80_0000}, "tie_even_down");
      step(1, 1, 64'd16777219,    0, 0, 0, {1'b1, 32'h4B80_0002}, "tie_even_up");
      step(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 4, {1'b1, 32'h5F80_0000}, "w64_all_ones");
      step(1, 1, 64'h8000_0000_0000_0000, 1, 1, -1, 33'd0, "all_min_signed");
      for (int i = 0; i < 8; i++) rand_step(1, 0, "drain_directed");

      // Back-to-back stream with bubbles trailing.
      for (int i = 0; i < 20; i++) rand_step(1, 1, "stream");
      for (int i = 0; i < 8; i++)  rand_step(1, 0, "stream_drain");

      // Stall mid-stream; in_valid is held high to show it is ignored.
      for (int i = 0; i < 10; i++) rand_step(1, 1, "pre_stall");
      for (int i = 0; i < 3; i++)  rand_step(0, 1, "stall");
      for (int i = 0; i < 10; i++) rand_step(1, 1, "post_stall");
      for (int i = 0; i < 8; i++)  rand_step(1, 0, "stall_drain");

      // Reset with operands in flight.
      for (int i = 0; i < 4; i++) rand_step(1, 1, "pre_reset");
      areset = 1'b1;
      #1 check_zero("reset_midflight");
      clear_model();
      @(posedge clk);
      #1 check_zero("reset_midflight_hold");
      areset = 1'b0;
      for (int i = 0; i < 10; i++) rand_step(1, 0, "post_reset_idle");
      for (int i = 0; i < 5; i++)  rand_step(1, 1, "post_reset_ops");
      for (int i = 0; i < 8; i++)  rand_step(1, 0, "post_reset_drain");

      // Randomised mixed traffic: occasional stalls and bubbles.
      for (int i = 0; i < 400; i++)
         rand_step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 4) != 0), "random");
      for (int i = 0; i < 8; i++) rand_step(1, 0, "final_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
